sim_monitor: RTL
================

SIM_MONITOR -- requirements
Module: sim_monitor

Interface
REQ-001 SHALL have parameter TAG, default 4'h1, meaning the dbus_cmd_addr_i[31:28] value that selects the monitor.
REQ-002 SHALL have parameter PASS_CODE, default 32'h777, meaning the result value that signals a pass.
REQ-003 SHALL have parameter TIMEOUT, default 1500, meaning watchdog limit in cycles (0 = watchdog disabled).
REQ-004 SHALL have parameter CONS_DEPTH, default 16, meaning console FIFO entries (power of 2, >=2).
REQ-005 SHALL have ports, in this order, one per line:
  clk_i  input  1  single clock, all logic on rising edge
  rst_i  input  1  asynchronous, active-high reset
  dbus_cmd_addr_i  input  32  CPU data-bus command address
  dbus_cmd_we_i  input  1  CPU data-bus write strobe
  dbus_write_data_i  input  32  CPU data-bus write data
  cons_ready_i  input  1  console sink ready
  cons_valid_o  output  1  console byte valid
  cons_data_o  output  8  console byte
  cons_overflow_o  output  1  sticky console-drop flag
  done_o  output  1  test finished (any terminal state)
  pass_o  output  1  finished with PASS_CODE
  fail_o  output  1  finished with other result value
  timeout_o  output  1  finished by watchdog
  result_o  output  32  captured result word
  cycle_o  output  64  cycles elapsed in RUN

Function
REQ-006 SHALL decode a hit as dbus_cmd_we_i=1 and dbus_cmd_addr_i[31:28]=TAG; register offset = dbus_cmd_addr_i[3:2].
REQ-007 SHALL implement states RUN, PASS, FAIL, TIMEOUT; PASS/FAIL/TIMEOUT are sticky until reset.
REQ-008 SHALL, in RUN, on a hit to offset 0, capture dbus_write_data_i into result_o and move to PASS if it equals PASS_CODE, else FAIL.
REQ-009 SHALL reflect a terminal state on done_o and the matching flag one cycle after the triggering edge (registered outputs, no combinational path from dbus inputs).
REQ-010 SHALL increment cycle_o by 1 each cycle in RUN and freeze it on entering any terminal state; 64-bit wrap without side effect.
REQ-011 SHALL keep a watchdog counter cleared by reset and by a hit to offset 2 (kick), incremented each RUN cycle otherwise.
REQ-012 SHALL move to TIMEOUT when TIMEOUT!=0 and the watchdog counter equals TIMEOUT-1 with no kick or result hit that cycle.
REQ-013 SHALL give a result hit priority over timeout in the same cycle; a kick in that cycle also prevents timeout.
REQ-014 SHALL ignore all dbus hits (result, kick, console) once in a terminal state; result_o unchanged.
REQ-015 SHALL ignore hits to offset 3 and to any address with a non-matching tag.
REQ-016 SHALL push dbus_write_data_i[7:0] into the console FIFO on a RUN-state hit to offset 1.
REQ-017 SHALL present the FIFO head on cons_data_o with cons_valid_o=1 when non-empty; pop on cons_valid_o & cons_ready_i.
REQ-018 SHALL, on push while full without simultaneous pop, drop the byte and set cons_overflow_o (sticky until reset).
REQ-019 SHALL accept push and pop in the same cycle when full (no drop, occupancy unchanged).
REQ-020 SHALL not bypass: a byte pushed into an empty FIFO appears on cons_valid_o the next cycle.
REQ-021 SHALL continue draining the console FIFO in terminal states.

Reset
REQ-022 SHALL, while rst_i=1, immediately force state RUN, cycle_o=0, watchdog=0, result_o=0, done_o/pass_o/fail_o/timeout_o=0, FIFO empty, cons_valid_o=0, cons_data_o=0, cons_overflow_o=0.
REQ-023 SHALL discard FIFO contents and any in-progress result on reset asserted mid-operation; counting restarts from 0 on the first edge after release.

Configuration
REQ-024 SHALL compile the console FIFO only when macro SIM_MONITOR_CONSOLE_EN is defined.
REQ-025 SHALL, without SIM_MONITOR_CONSOLE_EN, treat offset-1 hits as ignored and tie cons_valid_o, cons_data_o, cons_overflow_o to 0; all other behaviour unchanged.

Verification
REQ-026 Write 32'h777 to 32'h1000_0000 at RUN cycle 40 -> pass_o=1, done_o=1 next cycle, result_o=32'h777, cycle_o frozen at 41.
REQ-027 Write 32'h0000_0BAD to 32'h1000_0000 -> fail_o=1, pass_o=0, result_o=32'hBAD; later write of 32'h777 ignored.
REQ-028 TIMEOUT=100, no hits -> timeout_o=1 after 100 RUN cycles; with kick (32'h1000_0008) every 50 cycles -> no timeout for 1000 cycles.
REQ-029 Result write and watchdog expiry in same cycle -> pass_o/fail_o set, timeout_o stays 0.
REQ-030 Console enabled, CONS_DEPTH=4, cons_ready_i=0, write bytes 'A'..'E' to 32'h1000_0004 -> 'A'..'D' held, 'E' dropped, cons_overflow_o=1; raise ready -> 'A','B','C','D' drained in order.
REQ-031 Assert rst_i mid-run with FIFO holding 3 bytes and cycle_o=200 -> all outputs zero asynchronously, FIFO empty, counting restarts after release.

Source files
------------

// File: rtl/sim_monitor.sv
// sim_monitor: memory-mapped pass/fail/timeout monitor with an optional console FIFO.
// Console FIFO is compiled only when SIM_MONITOR_CONSOLE_EN is defined.
`default_nettype none

module sim_monitor #(
  parameter logic [3:0]  TAG        = 4'h1,
  parameter logic [31:0] PASS_CODE  = 32'h777,
  parameter int          TIMEOUT    = 1500,
  parameter int          CONS_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dbus_cmd_addr_i,
  input  logic        dbus_cmd_we_i,
  input  logic [31:0] dbus_write_data_i,
  input  logic        cons_ready_i,
  output logic        cons_valid_o,
  output logic [7:0]  cons_data_o,
  output logic        cons_overflow_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] result_o,
  output logic [63:0] cycle_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] watchdog;
  logic        in_run, hit, res_hit, kick_hit;
  logic [1:0]  offset;

  assign in_run   = (state == ST_RUN);
  assign hit      = dbus_cmd_we_i && (dbus_cmd_addr_i[31:28] == TAG);
  assign offset   = dbus_cmd_addr_i[3:2];
  assign res_hit  = hit && in_run && (offset == 2'd0);
  assign kick_hit = hit && (offset == 2'd2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_next;
  end

  // A result write or a kick in the expiry cycle both pre-empt the watchdog.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (res_hit)
          state_next = (dbus_write_data_i == PASS_CODE) ? ST_PASS : ST_FAIL;
        else if (WD_EN && (watchdog == WD_LAST) && !kick_hit)
          state_next = ST_TIMEOUT;
      end
      default: state_next = state;
    endcase
  end

  assign done_o    = !in_run;
  assign pass_o    = (state == ST_PASS);
  assign fail_o    = (state == ST_FAIL);
  assign timeout_o = (state == ST_TIMEOUT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_o  <= 64'd0;
      watchdog <= 32'd0;
      result_o <= 32'd0;
    end else if (in_run) begin
      cycle_o  <= cycle_o + 64'd1;
      watchdog <= kick_hit ? 32'd0 : watchdog + 32'd1;
      if (res_hit) result_o <= dbus_write_data_i;
    end
  end

`ifdef SIM_MONITOR_CONSOLE_EN
  localparam int AW = $clog2(CONS_DEPTH);

  logic [7:0]  mem [CONS_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        con_hit, empty, full, pop, push_ok;

  assign con_hit = hit && in_run && (offset == 2'd1);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && cons_ready_i;
  assign push_ok = con_hit && (!full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cons_overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (con_hit && full && !pop) cons_overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= dbus_write_data_i[7:0];
  end

  assign cons_valid_o = !empty;
  assign cons_data_o  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  logic unused_bits;
  assign unused_bits = ^{dbus_cmd_addr_i[27:4], dbus_cmd_addr_i[1:0]};
`else
  assign cons_valid_o    = 1'b0;
  assign cons_data_o     = 8'h00;
  assign cons_overflow_o = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{dbus_cmd_addr_i[27:4], dbus_cmd_addr_i[1:0], cons_ready_i};
`endif

endmodule

`default_nettype wire
